// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: shares one host sector channel (lba, rd/wr, ack, buffer
// bus) between NUM_REQ image requesters with round-robin grants.
//
// Handshake summary: a requester raises req_rd/req_wr (level) and holds it
// until its one-cycle req_done pulse; the arbiter raises sd_rd/sd_wr and holds
// it until sd_ack is sampled high, then waits for sd_ack to fall, which ends
// the transfer.
//
// Optional feature, macro SD_ARB_TIMEOUT_EN: abort an ISSUE that waits TIMEOUT
// cycles without ack, pulsing req_err and req_done together. Without the
// macro, ISSUE waits forever and req_err is tied low.
//
// dbg_state exposes the FSM state (0=IDLE, 1=ISSUE, 2=XFER).
module sd_sector_arbiter #(
  parameter int          NUM_REQ = 2,
  parameter logic [23:0] TIMEOUT = 24'd10000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_rd,
  input  logic [NUM_REQ-1:0]      req_wr,
  input  logic [NUM_REQ*32-1:0]   req_lba,
  input  logic [NUM_REQ*8-1:0]    req_buff_din,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_err,
  output logic [NUM_REQ-1:0]      req_buff_wr,
  output logic [13:0]             buff_addr,
  output logic [7:0]              buff_dout,
  output logic                    sd_rd,
  output logic                    sd_wr,
  output logic [31:0]             sd_lba,
  input  logic                    sd_ack,
  input  logic [13:0]             sd_buff_addr,
  input  logic [7:0]              sd_buff_dout,
  input  logic                    sd_buff_wr,
  output logic [7:0]              sd_buff_din,
  output logic [1:0]              dbg_state
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || NUM_REQ > 4 || TIMEOUT == 24'd0) begin : g_param_check
    $error("sd_sector_arbiter: NUM_REQ must be 1..4 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last;
  logic [NUM_REQ-1:0] pending;
  logic            pick_valid;
  logic [GW-1:0]   pick_idx;
  logic [31:0]     lba_arr [NUM_REQ];
  logic [7:0]      din_arr [NUM_REQ];

  // Index of the requester k places after base, wrapping at NUM_REQ.
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    return GW'((int'(base) + k) % NUM_REQ);
  endfunction

  assign pending   = req_rd | req_wr;
  assign buff_addr = sd_buff_addr;
  assign buff_dout = sd_buff_dout;
  assign dbg_state = state;

  // Unpack the flat per-requester LBA and write-data buses.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lba_arr[i] = req_lba[32*i +: 32];
      din_arr[i] = req_buff_din[8*i +: 8];
    end
  end

  // Round-robin pick: first pending requester after last; last itself is
  // checked at lowest priority so it is re-granted only when alone.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (pending[rr_idx(last, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_idx(last, k);
      end
    end
  end

  // Host write data always comes from the granted requester.
  assign sd_buff_din = din_arr[grant];

  // Buffer write strobes reach only the granted requester, and only in XFER.
  always_comb begin
    req_buff_wr = '0;
    if (state == S_XFER) req_buff_wr[grant] = sd_buff_wr;
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] to_cnt;

  // Arbitration and host handshake FSM, with ISSUE timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      last     <= GW'(NUM_REQ - 1);
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      sd_lba   <= '0;
      req_done <= '0;
      req_err  <= '0;
      to_cnt   <= '0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      unique case (state)
        S_IDLE: begin
          // While a done pulse is showing, the finished requester has not yet
          // had a cycle to drop its level request, so skip arbitration once.
          if (pick_valid && (req_done == '0)) begin
            grant  <= pick_idx;
            sd_lba <= lba_arr[pick_idx];
            sd_rd  <= req_rd[pick_idx];
            sd_wr  <= ~req_rd[pick_idx];
            to_cnt <= '0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= S_XFER;
          end else if (to_cnt == TIMEOUT - 24'd1) begin
            sd_rd           <= 1'b0;
            sd_wr           <= 1'b0;
            req_err[grant]  <= 1'b1;
            req_done[grant] <= 1'b1;
            last            <= grant;
            state           <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        S_XFER: begin
          if (!sd_ack) begin
            req_done[grant] <= 1'b1;
            last            <= grant;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign req_err = '0;

  // Arbitration and host handshake FSM; ISSUE waits for ack indefinitely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      last     <= GW'(NUM_REQ - 1);
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      sd_lba   <= '0;
      req_done <= '0;
    end else begin
      req_done <= '0;
      unique case (state)
        S_IDLE: begin
          // While a done pulse is showing, the finished requester has not yet
          // had a cycle to drop its level request, so skip arbitration once.
          if (pick_valid && (req_done == '0)) begin
            grant  <= pick_idx;
            sd_lba <= lba_arr[pick_idx];
            sd_rd  <= req_rd[pick_idx];
            sd_wr  <= ~req_rd[pick_idx];
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= S_XFER;
          end
        end
        S_XFER: begin
          if (!sd_ack) begin
            req_done[grant] <= 1'b1;
            last            <= grant;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Bench for sd_sector_arbiter with two requesters. Host requests and
// completion pulses are checked against expected queues by a negedge monitor.
module tb_sd_sector_arbiter;

`ifdef SD_ARB_TIMEOUT_EN
  localparam logic [23:0] TB_TO = 24'd16;
`else
  localparam logic [23:0] TB_TO = 24'd10000000;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  req_rd;
  logic [1:0]  req_wr;
  logic [63:0] req_lba;
  logic [15:0] req_buff_din;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [1:0]  req_buff_wr;
  logic [13:0] buff_addr;
  logic [7:0]  buff_dout;
  logic        sd_rd;
  logic        sd_wr;
  logic [31:0] sd_lba;
  logic        sd_ack;
  logic [13:0] sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int leak_cnt = 0;

  // Expected host requests {rd, wr, lba} and completions {err[1:0], done[1:0]}.
  logic [33:0] exp_issue_q[$];
  logic [3:0]  exp_done_q[$];
  logic [33:0] e_issue;
  logic [3:0]  e_done;
  logic        prev_issue = 1'b0;
  logic        prev_bw1 = 1'b0;

  sd_sector_arbiter #(.NUM_REQ(2), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .reset(rst),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_buff_din(req_buff_din),
    .req_done(req_done), .req_err(req_err), .req_buff_wr(req_buff_wr),
    .buff_addr(buff_addr), .buff_dout(buff_dout),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, expected to finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_rd = '0; req_wr = '0; req_lba = '0; req_buff_din = '0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Host side: wait for a request, ack it, run strobes, end the transfer and
  // wait for the completion pulse.
  task automatic host_serve(input int ack_delay, input int n_strobes, input logic [7:0] exp_din);
    int t;
    t = 0;
    while (!(sd_rd || sd_wr) && t < 100) begin tick(); t++; end
    check("issue_wait", 64'(t < 100), 64'd1);
    repeat (ack_delay) tick();
    sd_ack = 1'b1;
    tick();
    check("ack_clears_req", {sd_rd, sd_wr}, 2'b00);
    check("xfer_din_start", sd_buff_din, exp_din);
    for (int i = 0; i < n_strobes; i++) begin
      sd_buff_addr = 14'(i);
      sd_buff_dout = 8'(i) ^ 8'h3c;
      sd_buff_wr = 1'b1;
      tick();
      sd_buff_wr = 1'b0;
      tick();
    end
    check("xfer_din_end", sd_buff_din, exp_din);
    sd_ack = 1'b0;
    t = 0;
    while (req_done == 2'b00 && t < 100) begin tick(); t++; end
    check("done_wait", 64'(t < 100), 64'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if ((sd_rd || sd_wr) && !prev_issue) begin
        total++;
        if (exp_issue_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_issue: got rd=%0b wr=%0b lba=%h, expected no request", sd_rd, sd_wr, sd_lba);
        end else begin
          e_issue = exp_issue_q.pop_front();
          if ({sd_rd, sd_wr, sd_lba} !== e_issue) begin
            bad++;
            $display("FAIL issue: got %h expected %h", {sd_rd, sd_wr, sd_lba}, e_issue);
          end
        end
      end
      if (req_done != 2'b00 || req_err != 2'b00) begin
        total++;
        if (exp_done_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got err=%b done=%b, expected none", req_err, req_done);
        end else begin
          e_done = exp_done_q.pop_front();
          if ({req_err, req_done} !== e_done) begin
            bad++;
            $display("FAIL done: got %b expected %b", {req_err, req_done}, e_done);
          end
        end
      end
      if (req_buff_wr[1] && !prev_bw1) strobe_cnt++;
      if (req_buff_wr[0]) leak_cnt++;
      if (buff_dout !== sd_buff_dout || buff_addr !== sd_buff_addr) leak_cnt++;
    end
    prev_issue = sd_rd || sd_wr;
    prev_bw1 = req_buff_wr[1];
  end

  // Directed tests
  initial begin
    int t;
    do_reset();

    // Reset values
    check("rst_req", {sd_rd, sd_wr}, 2'b00);
    check("rst_lba", sd_lba, 32'h0);
    check("rst_done", req_done, 2'b00);
    check("rst_err", req_err, 2'b00);
    check("rst_state", dbg_state, 2'd0);
    check("rst_bw", req_buff_wr, 2'b00);

    // Single read with LBA change after grant
    req_lba[31:0] = 32'h00000123;
    exp_issue_q.push_back({1'b1, 1'b0, 32'h00000123});
    exp_done_q.push_back(4'b0001);
    req_rd[0] = 1'b1;
    tick();
    check("rd_latency", sd_rd, 1'b1);
    check("rd_lba", sd_lba, 32'h00000123);
    req_lba[31:0] = 32'hdeadbeef;
    tick();
    check("lba_hold", sd_lba, 32'h00000123);
    check("issue_hold", sd_rd, 1'b1);
    host_serve(1, 0, 8'h00);
    req_rd[0] = 1'b0;
    tick();
    check("done_one_cycle", req_done, 2'b00);

    // Round-robin with both requesters held
    do_reset();
    req_lba = {32'h00002000, 32'h00001000};
    for (int k = 0; k < 4; k++) begin
      exp_issue_q.push_back({1'b1, 1'b0, (k % 2 == 0) ? 32'h00001000 : 32'h00002000});
      exp_done_q.push_back((k % 2 == 0) ? 4'b0001 : 4'b0010);
    end
    req_rd = 2'b11;
    for (int k = 0; k < 4; k++) begin
      host_serve(1, 2, 8'h00);
      if (k < 3) begin
        tick();
        check("gap_idle", {sd_rd, sd_wr}, 2'b00);
      end
    end
    req_rd = 2'b00;
    repeat (3) tick();
    check("rr_quiet", {sd_rd, sd_wr}, 2'b00);

    // Buffer routing during grant 1
    do_reset();
    req_buff_din = {8'h22, 8'h11};
    sd_buff_wr = 1'b1;
    #1;
    check("bw_outside_xfer", req_buff_wr, 2'b00);
    tick();
    sd_buff_wr = 1'b0;
    strobe_cnt = 0;
    leak_cnt = 0;
    req_lba[63:32] = 32'h00000200;
    exp_issue_q.push_back({1'b1, 1'b0, 32'h00000200});
    exp_done_q.push_back(4'b0010);
    req_rd[1] = 1'b1;
    host_serve(1, 512, 8'h22);
    req_rd = 2'b00;
    tick();
    check("strobe_count", strobe_cnt, 512);
    check("routing_leaks", leak_cnt, 0);

    // Write data mux
    do_reset();
    req_buff_din = {8'hA5, 8'h5A};
    req_lba[63:32] = 32'h00000055;
    exp_issue_q.push_back({1'b0, 1'b1, 32'h00000055});
    exp_done_q.push_back(4'b0010);
    req_wr = 2'b10;
    host_serve(1, 4, 8'hA5);
    req_wr = 2'b00;
    tick();

    // Read wins over write on the same requester; write served next
    do_reset();
    req_lba[31:0] = 32'h00000042;
    exp_issue_q.push_back({1'b1, 1'b0, 32'h00000042});
    exp_issue_q.push_back({1'b0, 1'b1, 32'h00000042});
    exp_done_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    req_rd[0] = 1'b1;
    req_wr[0] = 1'b1;
    host_serve(1, 0, 8'h00);
    req_rd[0] = 1'b0;
    host_serve(1, 0, 8'h00);
    req_wr = 2'b00;
    tick();

    // Reset in XFER and in ISSUE, then a clean reissue
    do_reset();
    req_lba[31:0] = 32'h00000099;
    repeat (3) exp_issue_q.push_back({1'b1, 1'b0, 32'h00000099});
    exp_done_q.push_back(4'b0001);
    req_rd[0] = 1'b1;
    t = 0;
    while (!sd_rd && t < 20) begin tick(); t++; end
    check("rst_test_issue", sd_rd, 1'b1);
    tick();
    sd_ack = 1'b1;
    tick();
    check("in_xfer", dbg_state, 2'd2);
    #2;
    rst = 1'b1;
    sd_ack = 1'b0;
    #1;
    check("rst_xfer_state", dbg_state, 2'd0);
    check("rst_xfer_req", {sd_rd, sd_wr}, 2'b00);
    check("rst_xfer_done", req_done, 2'b00);
    tick();
    rst = 1'b0;
    tick();
    check("reissue", sd_rd, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_issue_req", {sd_rd, sd_wr}, 2'b00);
    tick();
    rst = 1'b0;
    host_serve(1, 0, 8'h00);
    req_rd = 2'b00;
    tick();
    check("done_one_cycle2", req_done, 2'b00);

`ifdef SD_ARB_TIMEOUT_EN
    // ISSUE timeout with no ack
    do_reset();
    req_lba[31:0] = 32'h00000777;
    exp_issue_q.push_back({1'b1, 1'b0, 32'h00000777});
    exp_done_q.push_back(4'b0101);
    req_rd[0] = 1'b1;
    tick();
    check("to_issue", sd_rd, 1'b1);
    t = 0;
    while (sd_rd && t < 100) begin tick(); t++; end
    check("to_cycles", t, 16);
    check("to_pulse", {req_err, req_done}, 4'b0101);
    check("to_state", dbg_state, 2'd0);
    req_rd = 2'b00;
    tick();
    check("to_pulse_end", {req_err, req_done}, 4'b0000);
`endif

    repeat (3) tick();
    check("issue_q_empty", exp_issue_q.size(), 0);
    check("done_q_empty", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_sector_arbiter.md
Name: sd_sector_arbiter

Overview:
- Shares the single host sector channel (lba, rd/wr, ack, buffer bus) between NUM_REQ image requesters, e.g. FDC drive images and the cassette/ROM image loader.
- Grants requesters round-robin, latches the granted LBA and direction, and sequences the rd/wr → ack → done handshake.
- Routes buffer traffic so only the granted requester sees buffer writes, and supplies host write data from the granted requester.
- Sits between the host sd interface (sd_bus / sd_bus_control signals) and the per-image controllers.

Parameters:
- NUM_REQ, 2, number of requesters (1..4).
- TIMEOUT, 24'd10000000, ISSUE-state cycle limit; used only with the optional feature.

Ports:
- clk  in  1  system clock; one clock domain for the whole block.
- reset  in  1  asynchronous, active-high reset.
- req_rd  in  NUM_REQ  per-requester read request; level, held until done.
- req_wr  in  NUM_REQ  per-requester write request; level, held until done.
- req_lba  in  NUM_REQ*32  per-requester sector LBA; slice i is bits [32i+31:32i].
- req_buff_din  in  NUM_REQ*8  per-requester write data to the host.
- req_done  out  NUM_REQ  one-cycle completion pulse per requester.
- req_err  out  NUM_REQ  one-cycle timeout pulse per requester.
- req_buff_wr  out  NUM_REQ  gated copy of sd_buff_wr, granted requester only.
- buff_addr  out  14  broadcast copy of sd_buff_addr.
- buff_dout  out  8  broadcast copy of sd_buff_dout.
- sd_rd  out  1  read request to host.
- sd_wr  out  1  write request to host.
- sd_lba  out  32  latched LBA of the granted request.
- sd_ack  in  1  host acknowledge; high for the whole transfer.
- sd_buff_addr  in  14  host buffer address.
- sd_buff_dout  in  8  host read data.
- sd_buff_wr  in  1  host buffer write strobe.
- sd_buff_din  out  8  combinational mux of req_buff_din[grant].

Behaviour:
- Reset values: state=IDLE; grant=0; last=NUM_REQ-1; sd_rd, sd_wr, req_done, req_err all 0; sd_lba=0.
- Requester i is pending when req_rd[i] or req_wr[i] is high.
- If both are high, read wins; the write is served on a later grant if still held.
- State IDLE:
  - With any pending request, pick the first pending requester searching from last+1 modulo NUM_REQ.
  - Register grant, sd_lba and direction; set sd_rd or sd_wr; go to ISSUE.
  - Latency: sd_rd/sd_wr is high on the cycle after the request is first seen in IDLE.
- State ISSUE:
  - Hold sd_rd/sd_wr and sd_lba stable.
  - When sd_ack is sampled high, clear sd_rd/sd_wr on the next cycle and go to XFER.
- State XFER:
  - req_buff_wr[grant] = sd_buff_wr; all other req_buff_wr bits are 0 (combinational, zero latency).
  - sd_buff_din = req_buff_din[grant] for the whole grant.
  - When sd_ack is sampled low, pulse req_done[grant] for one cycle, set last=grant, go to IDLE.
- Outside XFER, all req_buff_wr bits are 0.
- buff_addr and buff_dout always pass through combinationally.
- Minimum spacing: one IDLE cycle between a done pulse and the next sd_rd/sd_wr assertion.
- The same requester may be re-granted only if no other requester is pending.
- Requester drops its request mid-transaction: the transaction completes and done still pulses. Requests are not sampled again until IDLE.
- Changing req_lba after grant: no effect on the current transaction.
- Asynchronous reset mid-transaction:
  - Return to IDLE immediately; sd_rd/sd_wr go to 0.
  - No done pulse is issued; the requester reissues after reset.
- sd_ack already high in IDLE (stale): ignored; ISSUE waits for a sampled-high ack only after entry.
- NUM_REQ=1: arbitration degenerates; grant is always 0.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- When defined:
  - A 24-bit counter clears on ISSUE entry and increments each ISSUE cycle.
  - Reaching TIMEOUT-1 without ack: clear sd_rd/sd_wr, pulse req_err[grant] and req_done[grant] together, set last=grant, go to IDLE.
  - A late ack that arrives in IDLE is ignored.
- When undefined: ISSUE waits indefinitely; req_err is tied to 0; no counter logic is built.

Test Plan:
- Single read: req_rd[0]=1, req_lba[0]=32'h00000123.
  - Next cycle: sd_rd=1, sd_lba=32'h123.
  - Ack high 3 cycles later → sd_rd=0 the following cycle.
  - Ack low → req_done[0] pulses exactly one cycle.
- Round-robin: req_rd[0] and req_rd[1] asserted in the same cycle, both held.
  - Grant order is 0, 1, 0, 1 across four transactions; each sd_lba matches its requester.
- Buffer routing: during grant 1, 512 sd_buff_wr strobes with addr 0..511.
  - req_buff_wr[1] toggles 512 times; req_buff_wr[0] stays 0.
  - buff_dout equals sd_buff_dout every cycle.
- Write mux: req_wr[1]=1, req_buff_din[1]=8'hA5, req_buff_din[0]=8'h5A.
  - sd_wr=1; sd_buff_din=8'hA5 throughout XFER.
- Reset mid-transfer: assert reset in XFER.
  - sd_rd=sd_wr=0 immediately; no done pulse.
  - After release with the request still held, the transaction is reissued.
- Timeout (SD_ARB_TIMEOUT_EN, TIMEOUT=16): req_rd[0]=1, ack never asserted.
  - After 16 ISSUE cycles: req_err[0] and req_done[0] pulse together, sd_rd=0, state returns to IDLE.
